// File: rtl/dcache_arbiter_pkg.sv
// Shared defines for the data-cache port arbiter: widths, address mask, FSM encoding,
// byte-mask constants and the grant-selection helper.
`ifndef Addr_Width
`define Addr_Width 32
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Addr_Mask
`define Addr_Mask 32'hFFFF_FFFC
`endif

package dcache_arbiter_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_STORE = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_PREF  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [3:0] MASK_NONE = 4'h0;
    localparam logic [3:0] MASK_FULL = 4'hF;

    // Store beats load unless the store burst has run out while a load waits.
    function automatic logic [2:0] arb_select(input logic st_req,
                                              input logic ld_req,
                                              input logic pf_ok,
                                              input logic burst_full);
        if (ld_req && burst_full) return S_LOAD;
        if (st_req)               return S_STORE;
        if (ld_req)               return S_LOAD;
        if (pf_ok)                return S_PREF;
        return S_IDLE;
    endfunction

endpackage

// File: rtl/dcache_arbiter.sv
// Single-port data-cache arbiter between committed stores, loads and prefetch hints.
// Optional prefetch path enabled by defining DCACHE_ARB_PREFETCH_EN.
`ifndef Addr_Width
`define Addr_Width 32
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef Addr_Mask
`define Addr_Mask 32'hFFFF_FFFC
`endif

module dcache_arbiter
    import dcache_arbiter_pkg::*;
#(
    parameter int unsigned STORE_BURST_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ld_req,
    input  logic [`Addr_Width-1:0] ld_addr,
    output logic                   ld_done,
    output logic [`Data_Width-1:0] ld_data,
    input  logic                   st_req,
    input  logic [`Addr_Width-1:0] st_addr,
    input  logic [`Data_Width-1:0] st_data,
    input  logic [3:0]             st_mask,
    output logic                   st_done,
    input  logic                   pf_valid,
    input  logic [`Addr_Width-1:0] pf_addr,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [`Addr_Width-1:0] mem_addr,
    output logic [`Data_Width-1:0] mem_wdata,
    output logic [3:0]             mem_wmask,
    input  logic                   mem_ack,
    input  logic [`Data_Width-1:0] mem_rdata
);

    logic [2:0]             state;
    logic [2:0]             next_grant;
    logic [3:0]             burst_cnt;
    logic                   burst_full;
    logic                   pf_ok;
    logic [`Addr_Width-1:0] pf_addr_sel;
    logic                   idle;

    assign idle       = (state == S_IDLE);
    assign burst_full = (burst_cnt == 4'(STORE_BURST_MAX));
    assign mem_req    = (state == S_STORE) || (state == S_LOAD) || (state == S_PREF);
    assign mem_we     = (state == S_STORE);

    always_comb begin
        next_grant = arb_select(st_req, ld_req, pf_ok, burst_full);
    end

`ifdef DCACHE_ARB_PREFETCH_EN
    logic                   pf_pend;
    logic [`Addr_Width-1:0] pf_addr_q;
    logic                   pf_hit_ld;

    // A pending hint that the waiting load already covers is useless traffic.
    assign pf_hit_ld   = pf_pend && ld_req &&
                         ((pf_addr_q & `Addr_Mask) == (ld_addr & `Addr_Mask));
    assign pf_ok       = pf_pend && !pf_hit_ld;
    assign pf_addr_sel = pf_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pf_pend   <= 1'b0;
            pf_addr_q <= '0;
        end else if (pf_valid) begin
            pf_pend   <= 1'b1;
            pf_addr_q <= pf_addr;
        end else if (pf_hit_ld || (idle && next_grant == S_PREF)) begin
            pf_pend   <= 1'b0;
        end
    end
`else
    logic unused_pf;
    assign unused_pf   = ^{pf_valid, pf_addr};
    assign pf_ok       = 1'b0;
    assign pf_addr_sel = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
        end else if (!ld_req) begin
            burst_cnt <= '0;
        end else if (idle && next_grant == S_STORE) begin
            if (!burst_full) burst_cnt <= burst_cnt + 4'd1;
        end else if (idle && next_grant == S_LOAD) begin
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ld_done   <= 1'b0;
            st_done   <= 1'b0;
            ld_data   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= MASK_NONE;
        end else begin
            ld_done <= 1'b0;
            st_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    state <= next_grant;
                    case (next_grant)
                        S_STORE: begin
                            mem_addr  <= st_addr & `Addr_Mask;
                            mem_wdata <= st_data;
                            mem_wmask <= st_mask;
                        end
                        S_LOAD: begin
                            mem_addr  <= ld_addr & `Addr_Mask;
                            mem_wdata <= '0;
                            mem_wmask <= MASK_NONE;
                        end
                        S_PREF: begin
                            mem_addr  <= pf_addr_sel & `Addr_Mask;
                            mem_wdata <= '0;
                            mem_wmask <= MASK_NONE;
                        end
                        default: ;
                    endcase
                end
                // Done pulses are registered on the ack edge so they appear during RESP.
                S_STORE, S_LOAD, S_PREF: begin
                    if (mem_ack) begin
                        state <= S_RESP;
                        if (state == S_LOAD) begin
                            ld_data <= mem_rdata;
                            ld_done <= 1'b1;
                        end
                        if (state == S_STORE) st_done <= 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed self-checking bench for dcache_arbiter: vector table plus burst and
// prefetch sequences (prefetch checks follow DCACHE_ARB_PREFETCH_EN).
`timescale 1ns/1ps
module tb_dcache_arbiter;

    logic        clk = 1'b0;
    logic        rst, ld_req, st_req, pf_valid, mem_ack;
    logic [31:0] ld_addr, st_addr, st_data, pf_addr, mem_rdata;
    logic [3:0]  st_mask;
    logic        ld_done, st_done, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dcache_arbiter #(.STORE_BURST_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
        .st_done(st_done), .pf_valid(pf_valid), .pf_addr(pf_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        rst, ld;
        logic [31:0] la;
        logic        st;
        logic [31:0] sa, sd;
        logic [3:0]  sm;
        logic        ack;
        logic [31:0] rd;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wmask;
        logic        e_ldd, e_std;
        logic [31:0] e_ldata;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic l, input logic [31:0] la,
                                input logic s, input logic [31:0] sa, input logic [31:0] sd,
                                input logic [3:0] sm, input logic a, input logic [31:0] rd,
                                input logic er, input logic ew, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [3:0] em,
                                input logic eld, input logic est, input logic [31:0] eldata);
        vec_t v;
        v.rst = r; v.ld = l; v.la = la; v.st = s; v.sa = sa; v.sd = sd; v.sm = sm;
        v.ack = a; v.rd = rd; v.e_req = er; v.e_we = ew; v.e_addr = ea; v.e_wdata = ewd;
        v.e_wmask = em; v.e_ldd = eld; v.e_std = est; v.e_ldata = eldata;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; ld_req = 1'b0; st_req = 1'b0; pf_valid = 1'b0; mem_ack = 1'b0;
        ld_addr = '0; st_addr = '0; st_data = '0; st_mask = '0; pf_addr = '0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic count_reqs(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (mem_req) cnt++;
        end
    endtask

    initial begin
        int          grants, dual, extra;
        logic [9:0]  pattern;
        logic        prev;

        clear_inputs();
        //             rst ld la         st sa         sd            sm    ack rd           | req we addr       wdata         wmask ldd std ldata
        vecs[0]  = mk(1, 0, 32'h0,     0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 1, 32'h106,   0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h104,   32'h0,        4'h0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 32'h106,   0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h104,   32'h0,        4'h0, 0, 0, 32'h0);
        vecs[3]  = mk(0, 1, 32'h106,   0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h104,   32'h0,        4'h0, 0, 0, 32'h0);
        vecs[4]  = mk(0, 1, 32'h106,   0, 32'h0,     32'h0,        4'h0, 1, 32'hA1B2C3D4, 0, 0, 32'h104,   32'h0,        4'h0, 1, 0, 32'hA1B2C3D4);
        vecs[5]  = mk(0, 1, 32'h106,   0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h104,   32'h0,        4'h0, 0, 0, 32'hA1B2C3D4);
        vecs[6]  = mk(0, 0, 32'h0,     0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h104,   32'h0,        4'h0, 0, 0, 32'hA1B2C3D4);
        vecs[7]  = mk(0, 1, 32'h44,    1, 32'h20A,   32'hDEADBEEF, 4'h6, 0, 32'h0,        1, 1, 32'h208,   32'hDEADBEEF, 4'h6, 0, 0, 32'hA1B2C3D4);
        vecs[8]  = mk(0, 1, 32'h44,    1, 32'h20A,   32'hDEADBEEF, 4'h6, 1, 32'h0,        0, 0, 32'h208,   32'hDEADBEEF, 4'h6, 0, 1, 32'hA1B2C3D4);
        vecs[9]  = mk(0, 1, 32'h44,    0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h208,   32'hDEADBEEF, 4'h6, 0, 0, 32'hA1B2C3D4);
        vecs[10] = mk(0, 1, 32'h44,    0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h44,    32'h0,        4'h0, 0, 0, 32'hA1B2C3D4);
        vecs[11] = mk(0, 1, 32'h44,    0, 32'h0,     32'h0,        4'h0, 1, 32'h12345678, 0, 0, 32'h44,    32'h0,        4'h0, 1, 0, 32'h12345678);
        vecs[12] = mk(0, 0, 32'h0,     0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h44,    32'h0,        4'h0, 0, 0, 32'h12345678);
        vecs[13] = mk(0, 1, 32'h80,    0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        1, 0, 32'h80,    32'h0,        4'h0, 0, 0, 32'h12345678);
        vecs[14] = mk(1, 1, 32'h80,    0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0, 0, 32'h0);
        vecs[15] = mk(0, 0, 32'h0,     0, 32'h0,     32'h0,        4'h0, 1, 32'hFFFF,     0, 0, 32'h0,     32'h0,        4'h0, 0, 0, 32'h0);
        vecs[16] = mk(0, 0, 32'h0,     0, 32'h0,     32'h0,        4'h0, 0, 32'h0,        0, 0, 32'h0,     32'h0,        4'h0, 0, 0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; ld_req = vecs[i].ld; ld_addr = vecs[i].la;
            st_req = vecs[i].st; st_addr = vecs[i].sa; st_data = vecs[i].sd;
            st_mask = vecs[i].sm; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rd;
            tick();
            checks++;
            if (mem_req !== vecs[i].e_req || mem_we !== vecs[i].e_we ||
                mem_addr !== vecs[i].e_addr || mem_wdata !== vecs[i].e_wdata ||
                mem_wmask !== vecs[i].e_wmask || ld_done !== vecs[i].e_ldd ||
                st_done !== vecs[i].e_std || ld_data !== vecs[i].e_ldata) begin
                errors++;
                $display("FAIL vec%0d: got req=%b we=%b addr=%h wd=%h wm=%h ldd=%b std=%b ld=%h want req=%b we=%b addr=%h wd=%h wm=%h ldd=%b std=%b ld=%h",
                         i, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, ld_done, st_done, ld_data,
                         vecs[i].e_req, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata,
                         vecs[i].e_wmask, vecs[i].e_ldd, vecs[i].e_std, vecs[i].e_ldata);
            end
        end

        // Store burst against a waiting load: SSSSL repeating, acks returned immediately.
        do_reset();
        st_req = 1'b1; st_addr = 32'h700; st_data = 32'h55AA55AA; st_mask = 4'hF;
        ld_req = 1'b1; ld_addr = 32'h600;
        grants = 0; dual = 0; pattern = '0; prev = 1'b0;
        for (int c = 0; c < 200 && grants < 10; c++) begin
            tick();
            if (ld_done && st_done) dual++;
            if (mem_req && !prev) begin
                pattern[grants] = mem_we;
                grants++;
            end
            prev    = mem_req;
            mem_ack = mem_req;
        end
        chk("burst_grant_count", 32'(grants), 32'd10);
        chk("burst_pattern", 32'(pattern), 32'h1EF);
        chk("burst_dual_done", 32'(dual), 32'd0);

`ifdef DCACHE_ARB_PREFETCH_EN
        // Two hints while busy: only the newer one is issued, with no done pulse.
        do_reset();
        ld_req = 1'b1; ld_addr = 32'h500;
        tick();
        chk("pf_busy_load", {mem_req, mem_addr[30:0]}, {1'b1, 31'h500});
        pf_valid = 1'b1; pf_addr = 32'h200;
        tick();
        pf_addr = 32'h300;
        tick();
        pf_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1;
        tick();
        mem_ack = 1'b0; ld_req = 1'b0;
        tick();
        tick();
        chk("pf_issue", {mem_req, mem_we, mem_addr[29:0]}, {1'b1, 1'b0, 30'h300});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("pf_no_done", {30'd0, ld_done, st_done}, 32'd0);
        count_reqs(6, extra);
        chk("pf_old_not_issued", 32'(extra), 32'd0);

        // A hint covered by a waiting load to the same word is dropped.
        st_req = 1'b1; st_addr = 32'h40; st_data = 32'h0; st_mask = 4'h1;
        tick();
        pf_valid = 1'b1; pf_addr = 32'h300;
        tick();
        pf_valid = 1'b0; ld_req = 1'b1; ld_addr = 32'h302;
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; st_req = 1'b0;
        tick();
        tick();
        chk("drop_load_grant", {mem_req, mem_we, mem_addr[29:0]}, {1'b1, 1'b0, 30'h300});
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; ld_req = 1'b0;
        chk("drop_ld_done", 32'(ld_done), 32'd1);
        count_reqs(6, extra);
        chk("pf_dropped", 32'(extra), 32'd0);
`else
        // Without the prefetch path, hints never reach the memory port.
        do_reset();
        pf_valid = 1'b1; pf_addr = 32'h200;
        tick();
        pf_valid = 1'b0;
        count_reqs(6, extra);
        chk("pf_ignored", 32'(extra), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
